pwm_capture: RTL and testbench

//   Measures an external PWM waveform, the receive-side counterpart of pwm_controller.

---
 rtl/pwm_capture_if.sv | 39 +++
 rtl/pwm_capture.sv | 143 ++++++++++++++
 tb/tb_pwm_capture.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_capture_if.sv
// pwm_capture_if
//   Bundles the sample tick, the PWM input and the measurement results of
//   pwm_capture so the capture block and its driver share one port.
//   Ports (signals):
//     clock_enable  one-clock sample tick from the prescaler
//     pwm_in        asynchronous PWM input
//     high_time     ticks sampled high in the last measured cycle
//     period        ticks in the last measured cycle
//     valid         one-clock pulse when high_time/period update
//     stuck         1 = last report was a timeout (no edges)
//   master drives the tick and the pin; slave is the capture block.
interface pwm_capture_if #(
  parameter int COUNT_WIDTH = 8
);
  logic                   clock_enable;
  logic                   pwm_in;
  logic [COUNT_WIDTH-1:0] high_time;
  logic [COUNT_WIDTH-1:0] period;
  logic                   valid;
  logic                   stuck;

  modport master (
    output clock_enable,
    output pwm_in,
    input  high_time,
    input  period,
    input  valid,
    input  stuck
  );

  modport slave (
    input  clock_enable,
    input  pwm_in,
    output high_time,
    output period,
    output valid,
    output stuck
  );
endinterface

// File: rtl/pwm_capture.sv
// pwm_capture
//   Measures an external PWM waveform on the prescaler sample tick and
//   reports high time and period in ticks once per PWM cycle. A constant
//   input is flagged by a period-counter timeout.
//   Ports:
//     clock  system clock, all logic on its rising edge
//     reset  synchronous, active-high
//     cap    pwm_capture_if slave: clock_enable, pwm_in in;
//            high_time, period, valid, stuck out
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_SYNC   | waiting for the first rise after reset or a timeout
//   ST_HIGH   | inside the high phase of a cycle, counting high ticks
//   ST_LOW    | inside the low phase, waiting for the closing rise
module pwm_capture #(
  parameter int COUNT_WIDTH = 8
) (
  input logic          clock,
  input logic          reset,
  pwm_capture_if.slave cap
);

  localparam logic [1:0] ST_SYNC = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_LOW  = 2'd2;

  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = {COUNT_WIDTH{1'b1}};
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

  logic [1:0]             sync_q;
  logic                   prev_q,      prev_d;
  logic [1:0]             state_q,     state_d;
  logic [COUNT_WIDTH-1:0] hcnt_q,      hcnt_d;
  logic [COUNT_WIDTH-1:0] pcnt_q,      pcnt_d;
  logic [COUNT_WIDTH-1:0] high_time_q, high_time_d;
  logic [COUNT_WIDTH-1:0] period_q,    period_d;
  logic                   valid_q,     valid_d;
  logic                   stuck_q,     stuck_d;

  logic s;
  logic rise;
  logic timeout;

  assign s       = sync_q[1];
  assign rise    = ~prev_q & s;
  // A rise arriving with pcnt at MAX still closes a normal measurement.
  assign timeout = ~rise & (pcnt_q == CNT_MAX);

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    hcnt_d      = hcnt_q;
    pcnt_d      = pcnt_q;
    high_time_d = high_time_q;
    period_d    = period_q;
    stuck_d     = stuck_q;
    valid_d     = 1'b0;

    if (cap.clock_enable) begin
      prev_d = s;
      if (timeout) begin
        high_time_d = s ? CNT_MAX : '0;
        period_d    = CNT_MAX;
        stuck_d     = 1'b1;
        valid_d     = 1'b1;
        hcnt_d      = '0;
        pcnt_d      = '0;
        state_d     = ST_SYNC;
      end else begin
        case (state_q)
          ST_SYNC: begin
            if (rise) begin
              state_d = ST_HIGH;
              hcnt_d  = CNT_ONE;
              pcnt_d  = CNT_ONE;
            end else begin
              pcnt_d = pcnt_q + CNT_ONE;
            end
          end
          ST_HIGH: begin
            if (s) begin
              hcnt_d = hcnt_q + CNT_ONE;
              pcnt_d = pcnt_q + CNT_ONE;
            end else begin
              state_d = ST_LOW;
              pcnt_d  = pcnt_q + CNT_ONE;
            end
          end
          ST_LOW: begin
            if (rise) begin
              high_time_d = hcnt_q;
              period_d    = pcnt_q;
              stuck_d     = 1'b0;
              valid_d     = 1'b1;
              hcnt_d      = CNT_ONE;
              pcnt_d      = CNT_ONE;
              state_d     = ST_HIGH;
            end else begin
              pcnt_d = pcnt_q + CNT_ONE;
            end
          end
          default: begin
            state_d = ST_SYNC;
            hcnt_d  = '0;
            pcnt_d  = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q      <= 2'b00;
      // Starting high means a pin already high at release is not a rise.
      prev_q      <= 1'b1;
      state_q     <= ST_SYNC;
      hcnt_q      <= '0;
      pcnt_q      <= '0;
      high_time_q <= '0;
      period_q    <= '0;
      valid_q     <= 1'b0;
      stuck_q     <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], cap.pwm_in};
      prev_q      <= prev_d;
      state_q     <= state_d;
      hcnt_q      <= hcnt_d;
      pcnt_q      <= pcnt_d;
      high_time_q <= high_time_d;
      period_q    <= period_d;
      valid_q     <= valid_d;
      stuck_q     <= stuck_d;
    end
  end

  assign cap.high_time = high_time_q;
  assign cap.period    = period_q;
  assign cap.valid     = valid_q;
  assign cap.stuck     = stuck_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture
//   Drives PWM patterns on a 1-in-4 sample tick and checks reports against
//   a queue of expected {high_time, period, stuck} values.
module tb_pwm_capture;

  logic clock;
  logic reset;
  bit   ce_gate;
  int   ce_cnt;
  int   n_cmp;
  int   n_err;
  logic [16:0] sb[$];

  pwm_capture_if #(.COUNT_WIDTH(8)) ifc ();

  pwm_capture #(.COUNT_WIDTH(8)) dut (
    .clock (clock),
    .reset (reset),
    .cap   (ifc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Sample tick: one clock in every four, changed away from the rising edge.
  always @(negedge clock) begin
    ce_cnt = (ce_cnt + 1) % 4;
    ifc.clock_enable = ce_gate && (ce_cnt == 0);
  end

  // Scoreboard: every valid pulse must match the oldest expected report.
  always @(negedge clock) begin
    logic [16:0] exp_r;
    if (ifc.valid === 1'b1) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_valid: got ht=%0d per=%0d stuck=%0b, required no report",
                 ifc.high_time, ifc.period, ifc.stuck);
      end else begin
        exp_r = sb.pop_front();
        if ({ifc.high_time, ifc.period, ifc.stuck} !== exp_r) begin
          n_err++;
          $display("FAIL report @%0t: got ht=%0d per=%0d stuck=%0b, required ht=%0d per=%0d stuck=%0b",
                   $time, ifc.high_time, ifc.period, ifc.stuck,
                   exp_r[16:9], exp_r[8:1], exp_r[0]);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_ticks(input int n);
    repeat (n) begin
      do @(posedge clock); while (ifc.clock_enable !== 1'b1);
    end
    #1;
  endtask

  task automatic drive(input logic level, input int n);
    ifc.pwm_in = level;
    wait_ticks(n);
  endtask

  // Reset for one clock, released so the next tick is several clocks away.
  task automatic do_reset(input logic level);
    wait_ticks(1);
    ifc.pwm_in = level;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic check_drained(input string name);
    repeat (12) @(negedge clock);
    n_cmp++;
    if (sb.size() !== 0) begin
      n_err++;
      $display("FAIL %s_drained: got %0d pending reports, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ifc.pwm_in = 1'b0;
    repeat (6) @(negedge clock);
    n_cmp++;
    if (ifc.valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b, required 0", ifc.valid); end
    n_cmp++;
    if (ifc.high_time !== 8'd0) begin n_err++; $display("FAIL reset_high_time: got %0d, required 0", ifc.high_time); end
    n_cmp++;
    if (ifc.period !== 8'd0) begin n_err++; $display("FAIL reset_period: got %0d, required 0", ifc.period); end
    n_cmp++;
    if (ifc.stuck !== 1'b0) begin n_err++; $display("FAIL reset_stuck: got %b, required 0", ifc.stuck); end
    do_reset(1'b0);
  endtask

  task automatic test_steady();
    do_reset(1'b0);
    drive(1'b0, 4);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) sb.push_back({8'd4, 8'd16, 1'b0});
      drive(1'b1, 4);
      drive(1'b0, 12);
    end
    check_drained("steady");
  endtask

  task automatic test_duty();
    int highs[5] = '{1, 4, 8, 12, 15};
    foreach (highs[k]) begin
      do_reset(1'b0);
      drive(1'b0, 3);
      for (int i = 0; i < 4; i++) begin
        if (i > 0) sb.push_back({8'(highs[k]), 8'd16, 1'b0});
        drive(1'b1, highs[k]);
        drive(1'b0, 16 - highs[k]);
      end
      check_drained("duty");
    end
  endtask

  task automatic test_boundary();
    do_reset(1'b0);
    drive(1'b0, 2);
    drive(1'b1, 10);
    drive(1'b0, 245);
    // Closing rise lands exactly when pcnt is MAX: normal measurement.
    sb.push_back({8'd10, 8'd255, 1'b0});
    drive(1'b1, 10);
    // One tick longer: timeout while low, then the rise just restarts.
    sb.push_back({8'd0, 8'd255, 1'b1});
    drive(1'b0, 246);
    drive(1'b1, 2);
    drive(1'b0, 2);
    check_drained("boundary");
  endtask

  task automatic test_stuck(input logic level);
    logic [7:0] ht;
    ht = level ? 8'd255 : 8'd0;
    do_reset(level);
    sb.push_back({ht, 8'd255, 1'b1});
    sb.push_back({ht, 8'd255, 1'b1});
    wait_ticks(255);
    n_cmp++;
    if (sb.size() !== 2) begin
      n_err++;
      $display("FAIL stuck%0b_early: got %0d pending, required 2", level, sb.size());
    end
    wait_ticks(1);
    @(negedge clock);
    #1;
    n_cmp++;
    if (sb.size() !== 1) begin
      n_err++;
      $display("FAIL stuck%0b_first: got %0d pending, required 1", level, sb.size());
    end
    wait_ticks(600 - 256);
    check_drained("stuck");
  endtask

  task automatic test_recovery();
    wait_ticks(1);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) sb.push_back({8'd3, 8'd8, 1'b0});
      drive(1'b1, 3);
      drive(1'b0, 5);
    end
    check_drained("recovery");
  endtask

  task automatic test_ce_hold();
    do_reset(1'b0);
    drive(1'b0, 2);
    drive(1'b1, 4);
    drive(1'b0, 12);
    sb.push_back({8'd4, 8'd16, 1'b0});
    drive(1'b1, 2);
    ce_gate = 1'b0;
    repeat (100) begin
      @(posedge clock);
      #1;
      if ($urandom_range(0, 1) == 1) ifc.pwm_in = ~ifc.pwm_in;
    end
    n_cmp++;
    if (ifc.high_time !== 8'd4) begin n_err++; $display("FAIL ce_hold_high_time: got %0d, required 4", ifc.high_time); end
    n_cmp++;
    if (ifc.period !== 8'd16) begin n_err++; $display("FAIL ce_hold_period: got %0d, required 16", ifc.period); end
    n_cmp++;
    if (ifc.stuck !== 1'b0) begin n_err++; $display("FAIL ce_hold_stuck: got %b, required 0", ifc.stuck); end
    ifc.pwm_in = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    ce_gate = 1'b1;
    // Counters resume where they stopped: 2 + 2 high ticks, 16 total.
    drive(1'b1, 2);
    drive(1'b0, 12);
    sb.push_back({8'd4, 8'd16, 1'b0});
    drive(1'b1, 4);
    drive(1'b0, 4);
    check_drained("ce_hold");
  endtask

  task automatic test_reset_mid();
    do_reset(1'b0);
    drive(1'b0, 2);
    drive(1'b1, 4);
    drive(1'b0, 12);
    sb.push_back({8'd4, 8'd16, 1'b0});
    drive(1'b1, 2);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    n_cmp++;
    if (ifc.valid !== 1'b0) begin n_err++; $display("FAIL mid_reset_valid: got %b, required 0", ifc.valid); end
    n_cmp++;
    if (ifc.high_time !== 8'd0) begin n_err++; $display("FAIL mid_reset_high_time: got %0d, required 0", ifc.high_time); end
    n_cmp++;
    if (ifc.period !== 8'd0) begin n_err++; $display("FAIL mid_reset_period: got %0d, required 0", ifc.period); end
    // Pin still high at release: the next rise only opens a cycle.
    drive(1'b1, 2);
    drive(1'b0, 12);
    drive(1'b1, 4);
    drive(1'b0, 12);
    sb.push_back({8'd4, 8'd16, 1'b0});
    drive(1'b1, 4);
    drive(1'b0, 2);
    check_drained("reset_mid");
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    ce_cnt = 0;
    ce_gate = 1'b1;
    reset = 1'b1;
    ifc.clock_enable = 1'b0;
    ifc.pwm_in = 1'b0;
    test_reset();
    test_steady();
    test_duty();
    test_boundary();
    test_stuck(1'b1);
    test_stuck(1'b0);
    test_recovery();
    test_ce_hold();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
